// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: hex segment patterns
// (active-high {g,f,e,d,c,b,a}) and counter width helper.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Width needed to count 0..n-1, never less than one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-high {g..a} decoder; polarity handled by the caller.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg_c
);

  assign o_seg_c = SEG_LUT[i_nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit hex display driver with anti-ghosting blank window,
// frame-synchronous display update and optional leading-zero suppression.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned BLANK_CYCLES   = 500,
  parameter int unsigned BLANK_LEADING  = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1
) (
  input  logic                    JM1222HM_clk,
  input  logic                    JM1222HM_rst_n,
  input  logic [4*NUM_DIGITS-1:0] JM1222HM_value,
  input  logic [NUM_DIGITS-1:0]   JM1222HM_dp_in,
  input  logic                    JM1222HM_load,
  input  logic                    JM1222HM_enable,
  output logic [6:0]              JM1222HM_seg,
  output logic                    JM1222HM_dp,
  output logic [NUM_DIGITS-1:0]   JM1222HM_an,
  output logic                    JM1222HM_frame
);

  localparam int unsigned IW = idx_width(NUM_DIGITS);
  localparam int unsigned DW = idx_width(REFRESH_DIV);
  localparam int unsigned VW = 4 * NUM_DIGITS;

  localparam logic [6:0]            SEG_POL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_POL  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_POL  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [DW-1:0]         r_div;
  logic [IW-1:0]         r_idx;
  logic [VW-1:0]         r_shadow_val;
  logic [NUM_DIGITS-1:0] r_shadow_dp;
  logic [VW-1:0]         r_disp_val;
  logic [NUM_DIGITS-1:0] r_disp_dp;
  logic                  r_wrap_q;

  logic                  w_div_wrap;
  logic                  w_last_idx;
  logic                  w_frame_wrap;
  logic                  w_an_on;
  logic [3:0]            w_nib;
  logic                  w_dp_sel;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic                  w_upper_zero;
  logic                  w_blank;
  logic [6:0]            w_seg_hi;
  logic [6:0]            w_seg_lit;
  logic                  w_dp_lit;

  assign w_div_wrap   = (r_div == DW'(REFRESH_DIV - 1));
  assign w_last_idx   = (r_idx == IW'(NUM_DIGITS - 1));
  assign w_frame_wrap = w_div_wrap && w_last_idx;
  assign w_an_on      = JM1222HM_enable && (r_div >= DW'(BLANK_CYCLES));

  // Select the nibble, decimal point and anode of the digit being scanned
  always_comb begin
    w_nib    = 4'h0;
    w_dp_sel = 1'b0;
    w_onehot = '0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (r_idx == IW'(k)) begin
        w_nib       = r_disp_val[4*k +: 4];
        w_dp_sel    = r_disp_dp[k];
        w_onehot[k] = 1'b1;
      end
    end
  end

  // A digit is a leading zero when it and every more-significant nibble are zero
  always_comb begin
    w_upper_zero = 1'b1;
    w_blank      = 1'b0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
      w_upper_zero = w_upper_zero && (r_disp_val[4*k +: 4] == 4'h0);
      if (r_idx == IW'(k)) begin
        w_blank = (BLANK_LEADING != 0) && w_upper_zero && !r_disp_dp[k];
      end
    end
  end

  hex_to_seg7 u_dec (
    .i_nib   (w_nib),
    .o_seg_c (w_seg_hi)
  );

  assign w_seg_lit = w_blank ? SEG_BLANK : w_seg_hi;
  assign w_dp_lit  = !w_blank && w_dp_sel;

  // Scan counters, shadow/display capture and registered pin outputs
  always_ff @(posedge JM1222HM_clk or negedge JM1222HM_rst_n) begin
    if (!JM1222HM_rst_n) begin
      r_div          <= '0;
      r_idx          <= '0;
      r_shadow_val   <= '0;
      r_shadow_dp    <= '0;
      r_disp_val     <= '0;
      r_disp_dp      <= '0;
      r_wrap_q       <= 1'b0;
      JM1222HM_seg   <= SEG_BLANK ^ SEG_POL;
      JM1222HM_dp    <= DP_POL;
      JM1222HM_an    <= AN_POL;
      JM1222HM_frame <= 1'b0;
    end else begin
      r_div <= w_div_wrap ? '0 : r_div + DW'(1);
      if (w_div_wrap) begin
        r_idx <= w_last_idx ? '0 : r_idx + IW'(1);
      end
      // Display takes the shadow as it stood before any same-cycle load
      if (w_frame_wrap) begin
        r_disp_val <= r_shadow_val;
        r_disp_dp  <= r_shadow_dp;
      end
      if (JM1222HM_load) begin
        r_shadow_val <= JM1222HM_value;
        r_shadow_dp  <= JM1222HM_dp_in;
      end
      r_wrap_q       <= w_frame_wrap;
      JM1222HM_frame <= r_wrap_q;
      JM1222HM_seg   <= w_seg_lit ^ SEG_POL;
      JM1222HM_dp    <= w_dp_lit ^ DP_POL;
      JM1222HM_an    <= (w_an_on ? w_onehot : '0) ^ AN_POL;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a cycle-count based reference model
// predicts each registered output and a monitor compares it on the falling edge.
module tb_seg7_scan_driver;

  localparam int unsigned ND    = 4;
  localparam int unsigned RD    = 4;
  localparam int unsigned BC    = 1;
  localparam int unsigned FRAME = RD * ND;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic [15:0] value  = 16'h0;
  logic [3:0]  dp_in  = 4'h0;
  logic        load   = 1'b0;
  logic        enable = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame;

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  int unsigned m_edges     = 0;
  logic [15:0] m_shadow_v  = 16'h0;
  logic [3:0]  m_shadow_dp = 4'h0;
  logic [15:0] m_disp_v    = 16'h0;
  logic [3:0]  m_disp_dp   = 4'h0;

  // Active-high {g..a} glyphs for 0..F
  logic [6:0] hex_lut [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  seg7_scan_driver #(
    .NUM_DIGITS     (ND),
    .REFRESH_DIV    (RD),
    .BLANK_CYCLES   (BC),
    .BLANK_LEADING  (1),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .JM1222HM_clk    (clk),
    .JM1222HM_rst_n  (rst_n),
    .JM1222HM_value  (value),
    .JM1222HM_dp_in  (dp_in),
    .JM1222HM_load   (load),
    .JM1222HM_enable (enable),
    .JM1222HM_seg    (seg),
    .JM1222HM_dp     (dp),
    .JM1222HM_an     (an),
    .JM1222HM_frame  (frame)
  );

  always #5 clk = ~clk;

  // Output expected after edge e (counted from reset release), from slot arithmetic
  function automatic exp_t predict(input int unsigned e, input logic en,
                                   input logic [15:0] v, input logic [3:0] d);
    exp_t        x;
    int unsigned digit;
    int unsigned pos;
    logic [15:0] above;
    logic [3:0]  nib;
    bit          blank;
    digit   = (e / RD) % ND;
    pos     = e % RD;
    above   = v >> (4 * digit);
    nib     = above[3:0];
    blank   = (digit != 0) && (above == 16'h0) && !d[digit];
    x.seg   = blank ? 7'h7F : ~hex_lut[nib];
    x.dp    = blank ? 1'b1 : ~d[digit];
    x.an    = (en && pos >= BC) ? ~(4'b0001 << digit) : 4'hF;
    x.frame = (e != 0) && (e % FRAME == 0);
    return x;
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: push the prediction for every active edge
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_edges     = 0;
      m_shadow_v  = 16'h0;
      m_shadow_dp = 4'h0;
      m_disp_v    = 16'h0;
      m_disp_dp   = 4'h0;
      exp_q.delete();
    end else begin
      exp_q.push_back(predict(m_edges, enable, m_disp_v, m_disp_dp));
      if (m_edges % FRAME == FRAME - 1) begin
        m_disp_v  = m_shadow_v;
        m_disp_dp = m_shadow_dp;
      end
      if (load) begin
        m_shadow_v  = value;
        m_shadow_dp = dp_in;
      end
      m_edges++;
    end
  end

  // Monitor: compare on the falling edge, away from the active edge
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp", 7'(dp), 7'h1);
      chk("rst_an", 7'(an), 7'hF);
      chk("rst_frame", 7'(frame), 7'h0);
    end else if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      chk("seg", seg, x.seg);
      chk("dp", 7'(dp), 7'(x.dp));
      chk("an", 7'(an), 7'(x.an));
      chk("frame", 7'(frame), 7'(x.frame));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    tick(1);
    load  = 1'b0;
  endtask

  initial begin
    logic [15:0] mask;
    int          r;
    enable = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2 * FRAME);

    do_load(16'h12AF, 4'b0100);
    tick(3 * FRAME);
    do_load(16'h00C0, 4'b0000);
    tick(2 * FRAME);
    do_load(16'h00C0, 4'b1000);
    tick(2 * FRAME);

    // Load sampled on the frame-wrap edge
    for (int i = 0; i < int'(FRAME) && (m_edges % FRAME) != FRAME - 1; i++) tick(1);
    do_load(16'hBEEF, 4'b0001);
    tick(3 * FRAME);

    tick(2);
    enable = 1'b0;
    tick(7);
    enable = 1'b1;
    tick(2 * FRAME);

    do_load(16'h5555, 4'b0000);
    tick(2 * FRAME + 2);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2 * FRAME);

    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        case ($urandom_range(0, 3))
          0:       mask = 16'h000F;
          1:       mask = 16'h00FF;
          2:       mask = 16'h0FFF;
          default: mask = 16'hFFFF;
        endcase
        do_load(16'($urandom) & mask, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
      end else if (r < 12) begin
        enable = ~enable;
        tick(1);
      end else if (r < 13) begin
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
      end else begin
        tick(1);
      end
    end
    enable = 1'b1;
    tick(FRAME);

    if (tests < 12) begin
      fails++;
      $display("FAIL check_count: got %0d expected at least 12", tests);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
